// File: rtl/k12_nonce_collector.sv
// k12_nonce_collector: captures per-core winning nonces and round-robins them into a show-ahead result FIFO
module k12_nonce_collector #(
  parameter int NCORE = 4,
  parameter int DEPTH = 8,
  parameter int CW = (NCORE > 1) ? $clog2(NCORE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NCORE-1:0]          store,
  input  logic [64*NCORE-1:0]       nonce_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_nonce,
  output logic [CW-1:0]             out_core,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [NCORE-1:0] pend, take, gmask;
  logic [63:0]      hold [NCORE];
  logic [63:0]      mem_n [DEPTH];
  logic [CW-1:0]    mem_c [DEPTH];
  logic [CW-1:0]    rr_ptr, g;
  logic [CW:0]      idx;
  logic [AW-1:0]    wp, rp;
  logic             gnt, pop;
  logic [16:0]      dsum;
  assign out_valid = level != '0;
  assign pop       = out_valid & out_ready;
  assign out_nonce = mem_n[rp];
  assign out_core  = mem_c[rp];
  // Search from rr_ptr, wrapping; the first pending core wins while the FIFO has room.
  always_comb begin
    gnt = 1'b0;
    g   = '0;
    idx = '0;
    for (int k = 0; k < NCORE; k++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(k);
      idx = (idx >= (CW+1)'(NCORE)) ? idx - (CW+1)'(NCORE) : idx;
      if (!gnt && pend[idx[CW-1:0]] && level < (AW+1)'(DEPTH)) begin
        gnt = 1'b1;
        g   = idx[CW-1:0];
      end
    end
  end
  // A strobe on a core being granted this cycle recaptures instead of dropping.
  always_comb begin
    dsum = {1'b0, drop_cnt};
    for (int i = 0; i < NCORE; i++) begin
      gmask[i] = gnt && (g == CW'(i));
      take[i]  = store[i] & (~pend[i] | gmask[i]);
      dsum     = dsum + 17'(store[i] & ~take[i]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      rr_ptr   <= '0;
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < NCORE; i++) hold[i] <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        mem_n[d] <= '0;
        mem_c[d] <= '0;
      end
    end else if (flush) begin
      pend   <= '0;
      rr_ptr <= '0;
      wp     <= '0;
      rp     <= '0;
      level  <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++)
        if (take[i]) hold[i] <= nonce_in[64*i +: 64];
      pend <= take | (pend & ~gmask);
      if (gnt) begin
        mem_n[wp] <= hold[g];
        mem_c[wp] <= g;
        wp        <= wp + 1'b1;
        rr_ptr    <= (g == CW'(NCORE-1)) ? '0 : g + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      level    <= level + (AW+1)'(gnt) - (AW+1)'(pop);
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end
endmodule

// File: tb/tb_k12_nonce_collector.sv
// tb_k12_nonce_collector: directed scenarios plus randomized traffic against a queue-based reference model
module tb_k12_nonce_collector;
  localparam int NCORE = 4;
  localparam int DEPTH = 8;
  localparam int CW = 2;
  logic clk = 0, rst = 1, flush = 0, out_ready = 0;
  logic [NCORE-1:0] store = '0;
  logic [64*NCORE-1:0] nonce_in = '0;
  logic out_valid;
  logic [63:0] out_nonce;
  logic [CW-1:0] out_core;
  logic [3:0] level;
  logic [15:0] drop_cnt;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int core; logic [63:0] n;} ent_t;
  ent_t q[$];
  bit m_pend[NCORE];
  logic [63:0] m_hold[NCORE];
  int m_rr = 0, m_drop = 0, gi;
  logic [15:0] d0;

  always #5 clk = ~clk;

  k12_nonce_collector #(.NCORE(NCORE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .store(store), .nonce_in(nonce_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .out_core(out_core), .level(level), .drop_cnt(drop_cnt)
  );

  // Reference: pending slots, a result queue and a drop tally, updated per clock edge
  always @(posedge clk) begin
    if (!rst || flush) begin
      q.delete();
      m_rr = 0;
      for (int i = 0; i < NCORE; i++) m_pend[i] = 0;
      if (!rst) m_drop = 0;
    end else begin
      gi = -1;
      if (q.size() < DEPTH)
        for (int k = 0; k < NCORE; k++)
          if (gi < 0 && m_pend[(m_rr + k) % NCORE]) gi = (m_rr + k) % NCORE;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (gi >= 0) begin
        q.push_back('{gi, m_hold[gi]});
        m_pend[gi] = 0;
        m_rr = (gi + 1) % NCORE;
      end
      for (int i = 0; i < NCORE; i++)
        if (store[i]) begin
          if (!m_pend[i]) begin
            m_hold[i] = nonce_in[64*i +: 64];
            m_pend[i] = 1;
          end else if (m_drop < 65535) m_drop++;
        end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(int c, logic [63:0] v);
    nonce_in[64*c +: 64] = v;
  endtask

  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic test_reset();
    #2 rst = 0;
    step(3);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
    n_cmp++; if (out_nonce !== 64'd0 || out_core !== 2'd0) begin n_bad++; $display("FAIL rst_head got=%h/%0d exp=0/0", out_nonce, out_core); end
    rst = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0 || level !== 4'd0 || drop_cnt !== 16'd0) begin
        n_bad++; $display("FAIL idle_%0d got v=%0b l=%0d d=%0d exp 0/0/0", c, out_valid, level, drop_cnt);
      end
    end
  endtask

  task automatic test_single();
    store = 4'b0100;
    put(2, 64'h0000_0000_DEAD_BEEF);
    step();
    store = '0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early got=%0b exp=0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    n_cmp++; if (out_nonce !== 64'hDEADBEEF) begin n_bad++; $display("FAIL single_nonce got=%h exp=deadbeef", out_nonce); end
    n_cmp++; if (out_core !== 2'd2) begin n_bad++; $display("FAIL single_core got=%0d exp=2", out_core); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level got=%0d exp=1", level); end
    out_ready = 1;
    step();
    out_ready = 0;
    n_cmp++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop got l=%0d v=%0b exp 0/0", level, out_valid); end
  endtask

  task automatic test_round_robin();
    do_flush();
    store = 4'b1111;
    for (int c = 0; c < 4; c++) put(c, 64'(10 + c));
    step();
    store = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (level !== 4'(k + 1)) begin n_bad++; $display("FAIL rr0_level%0d got=%0d exp=%0d", k, level, k + 1); end
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_core !== 2'(k) || out_nonce !== 64'(10 + k)) begin
        n_bad++; $display("FAIL rr0_order%0d got=%0d/%0d exp=%0d/%0d", k, out_core, out_nonce, k, 10 + k);
      end
      step();
    end
    out_ready = 0;
    store = 4'b0010;
    put(1, 64'd99);
    step();
    store = '0;
    step();
    out_ready = 1;
    step();
    out_ready = 0;
    store = 4'b1111;
    for (int c = 0; c < 4; c++) put(c, 64'(20 + c));
    step();
    store = '0;
    step(4);
    n_cmp++; if (level !== 4'd4) begin n_bad++; $display("FAIL rr2_level got=%0d exp=4", level); end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_core !== 2'((k + 2) % 4) || out_nonce !== 64'(20 + (k + 2) % 4)) begin
        n_bad++; $display("FAIL rr2_order%0d got=%0d/%0d exp=%0d/%0d", k, out_core, out_nonce, (k + 2) % 4, 20 + (k + 2) % 4);
      end
      step();
    end
    out_ready = 0;
  endtask

  task automatic test_full_drop();
    do_flush();
    d0 = drop_cnt;
    for (int k = 0; k < 8; k++) begin
      store = 4'b0010;
      put(1, 64'(100 + k));
      step();
      store = '0;
      step();
    end
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL full_level got=%0d exp=8", level); end
    store = 4'b0010; put(1, 64'd108); step(); store = '0; step();
    n_cmp++; if (level !== 4'd8 || drop_cnt !== d0) begin n_bad++; $display("FAIL full_held got l=%0d d=%0d exp 8/%0d", level, drop_cnt, d0); end
    store = 4'b0010; put(1, 64'd109); step(); store = '0;
    n_cmp++; if (drop_cnt !== d0 + 16'd1) begin n_bad++; $display("FAIL full_drop got=%0d exp=%0d", drop_cnt, d0 + 1); end
    out_ready = 1; step(); out_ready = 0;
    n_cmp++; if (level !== 4'd7) begin n_bad++; $display("FAIL full_nobypass got=%0d exp=7", level); end
    step();
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL full_refill got=%0d exp=8", level); end
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (out_nonce !== 64'(100 + k) || out_core !== 2'd1) begin
        n_bad++; $display("FAIL full_drain%0d got=%0d/%0d exp=%0d/1", k, out_nonce, out_core, 100 + k);
      end
      step();
    end
    out_ready = 0;
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL full_empty got=%0d exp=0", level); end
  endtask

  task automatic test_recapture();
    do_flush();
    d0 = drop_cnt;
    store = 4'b0001;
    put(0, 64'h44);
    step();
    put(0, 64'h55);
    step();
    store = '0;
    step();
    n_cmp++; if (level !== 4'd2 || drop_cnt !== d0) begin n_bad++; $display("FAIL recap_state got l=%0d d=%0d exp 2/%0d", level, drop_cnt, d0); end
    out_ready = 1;
    n_cmp++; if (out_nonce !== 64'h44) begin n_bad++; $display("FAIL recap_first got=%h exp=44", out_nonce); end
    step();
    n_cmp++; if (out_nonce !== 64'h55 || out_core !== 2'd0) begin n_bad++; $display("FAIL recap_second got=%h/%0d exp=55/0", out_nonce, out_core); end
    step();
    out_ready = 0;
  endtask

  task automatic test_flush();
    do_flush();
    d0 = drop_cnt;
    for (int k = 0; k < 5; k++) begin
      store = 4'b1000; put(3, 64'(200 + k)); step(); store = '0; step();
    end
    n_cmp++; if (level !== 4'd5) begin n_bad++; $display("FAIL flush_pre got=%0d exp=5", level); end
    store = 4'b0011; put(0, 64'd300); put(1, 64'd301); step();
    store = 4'b0001; flush = 1; step(); flush = 0; store = '0;
    n_cmp++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear got l=%0d v=%0b exp 0/0", level, out_valid); end
    n_cmp++; if (drop_cnt !== d0) begin n_bad++; $display("FAIL flush_drop got=%0d exp=%0d", drop_cnt, d0); end
    step(3);
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL flush_pend got=%0d exp=0", level); end
  endtask

  task automatic test_random();
    do_flush();
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(99) == 0);
      rst = (c != 1500);
      for (int i = 0; i < NCORE; i++) begin
        store[i] = ($urandom_range(99) < 25);
        put(i, {$urandom, $urandom});
      end
      out_ready = ($urandom_range(99) < (((c / 300) % 2) ? 15 : 70));
      step();
      n_cmp++; if (level !== 4'(q.size()) || out_valid !== (q.size() != 0)) begin
        n_bad++; $display("FAIL rnd_level c=%0d got=%0d/%0b exp=%0d", c, level, out_valid, q.size());
      end
      n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_bad++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_cnt, m_drop); end
      if (q.size() != 0) begin
        n_cmp++; if (out_nonce !== q[0].n || out_core !== 2'(q[0].core)) begin
          n_bad++; $display("FAIL rnd_head c=%0d got=%h/%0d exp=%h/%0d", c, out_nonce, out_core, q[0].n, q[0].core);
        end
      end
    end
    rst = 1; flush = 0; store = '0; out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_drop();
    test_recapture();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
